// File: rtl/spike_train_gen_pkg.sv
// Shared constants and types for the spike-train generator and its neuron neighbours.
package spike_train_gen_pkg;

    // Number of spike lines feeding one neuron's spikes_in.
    localparam int NUM_SPIKES_DEF = 8;

    // Width of one spike time; the all-ones code means "no spike".
    localparam int TBITS_DEF = 4;

    // Neuron-side weight width and firing threshold, kept here so every block agrees.
    localparam int WBITS     = 8;
    localparam int THRESHOLD = 64;

    // Window sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/spike_train_gen.sv
// Converts a vector of spike times into one gamma window of single-cycle
// spike pulses, followed by an optional idle gap before the next vector.
module spike_train_gen
    import spike_train_gen_pkg::*;
#(
    parameter int NUM_SPIKES = NUM_SPIKES_DEF,
    parameter int TBITS      = TBITS_DEF,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        times_valid,
    input  logic [NUM_SPIKES*TBITS-1:0] times_in,
    output logic                        times_ready,
    input  logic                        abort,
    output logic [NUM_SPIKES-1:0]       spikes_out,
    output logic                        gamma_start,
    output logic                        gamma_done,
    output logic                        busy
);

    // All-ones time never fires; the window ends on the code just below it.
    localparam logic [TBITS-1:0] T_NONE = '1;
    localparam logic [TBITS-1:0] T_LAST = {{(TBITS-1){1'b1}}, 1'b0};

    localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_e                            state_q, state_d;
    logic [TBITS-1:0]                  t_q, t_d;
    logic [GW-1:0]                     gap_q, gap_d;
    logic [NUM_SPIKES-1:0][TBITS-1:0]  times_q, times_d;
    logic [NUM_SPIKES-1:0]             spikes_q, spikes_d;

    // Ready only in IDLE, and a simultaneous abort vetoes the transfer.
    assign times_ready = (state_q == ST_IDLE) && !abort;

    // Next-state logic: abort dominates; times are latched only on a transfer.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        gap_d   = gap_q;
        times_d = times_q;
        if (abort) begin
            state_d = ST_IDLE;
            t_d     = '0;
            gap_d   = '0;
            times_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (times_valid) begin
                        times_d = times_in;
                        t_d     = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (t_q == T_LAST) begin
                        t_d = '0;
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        t_d = t_q + TBITS'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

    // Per-line comparators on next-state values so the registered pulse lines up with t.
    for (genvar gi = 0; gi < NUM_SPIKES; gi++) begin : g_line
        assign spikes_d[gi] = (state_d == ST_RUN) && (t_d == times_d[gi]) && (times_d[gi] != T_NONE);
    end

    // State, counters, stored times and spike pulses.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            gap_q    <= '0;
            times_q  <= '0;
            spikes_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            gap_q    <= gap_d;
            times_q  <= times_d;
            spikes_q <= spikes_d;
        end
    end

    assign spikes_out  = spikes_q;
    assign busy        = (state_q != ST_IDLE);
    assign gamma_start = (state_q == ST_RUN) && (t_q == '0);

    // Done marks the final cycle of the window; an abort in that cycle cancels it.
    always_comb begin
        gamma_done = 1'b0;
        if (HAS_GAP) begin
            gamma_done = (state_q == ST_GAP) && (gap_q == GAP_LAST) && !abort;
        end else begin
            gamma_done = (state_q == ST_RUN) && (t_q == T_LAST) && !abort;
        end
    end

endmodule

// File: tb/tb_spike_train_gen.sv
// Directed bench for spike_train_gen: one instance with a 2-cycle gap, one with no gap.
module tb_spike_train_gen;

    logic        clk;
    logic        rst_l;

    logic        valid_a, abort_a, ready_a, start_a, done_a, busy_a;
    logic [31:0] times_a;
    logic [7:0]  spikes_a;

    logic        valid_b, abort_b, ready_b, start_b, done_b, busy_b;
    logic [31:0] times_b;
    logic [7:0]  spikes_b;

    int n_checks;
    int n_fail;

    spike_train_gen #(.NUM_SPIKES(8), .TBITS(4), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_l(rst_l), .times_valid(valid_a), .times_in(times_a),
        .times_ready(ready_a), .abort(abort_a), .spikes_out(spikes_a),
        .gamma_start(start_a), .gamma_done(done_a), .busy(busy_a)
    );

    spike_train_gen #(.NUM_SPIKES(8), .TBITS(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_l(rst_l), .times_valid(valid_b), .times_in(times_b),
        .times_ready(ready_b), .abort(abort_b), .spikes_out(spikes_b),
        .gamma_start(start_b), .gamma_done(done_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected spike vector k cycles after the accept cycle (k = 1 is the first RUN cycle).
    function automatic logic [7:0] model_spikes(input logic [31:0] tv, input int k);
        logic [7:0] r;
        logic [3:0] tm;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            tm = tv[i*4 +: 4];
            if (k >= 1 && k <= 15 && tm != 4'hF && int'(tm) == k - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] b2b_data(input int c);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) d[i*4 +: 4] = 4'((c * 3 + i) % 16);
        return d;
    endfunction

    task automatic test_reset();
        rst_l = 1'b0; valid_a = 0; abort_a = 0; times_a = '0;
        valid_b = 0; abort_b = 0; times_b = '0;
        #2;
        n_checks++; if (spikes_a !== 8'h00) begin n_fail++; $display("FAIL reset_spikes: got %h expected 00", spikes_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        n_checks++; if ({start_a, done_a} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {start_a, done_a}); end
        n_checks++; if ({busy_b, start_b, done_b, ready_b} !== 4'b0001) begin n_fail++; $display("FAIL reset_dut_b: got %b expected 0001", {busy_b, start_b, done_b, ready_b}); end
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        $display("test_reset done");
    endtask

    // Ramp of times 0..7: line i fires i+1 cycles after the accept cycle.
    task automatic test_ramp();
        logic [31:0] tv;
        tv = 32'h7654_3210;
        valid_a = 1; times_a = tv;
        #1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL ramp_ready: got %b expected 1", ready_a); end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            valid_a = 0;
            #1;
            n_checks++; if (spikes_a !== model_spikes(tv, k)) begin n_fail++; $display("FAIL ramp_spikes k=%0d: got %h expected %h", k, spikes_a, model_spikes(tv, k)); end
            n_checks++; if (start_a !== (k == 1)) begin n_fail++; $display("FAIL ramp_start k=%0d: got %b expected %b", k, start_a, (k == 1)); end
            n_checks++; if (done_a !== (k == 17)) begin n_fail++; $display("FAIL ramp_done k=%0d: got %b expected %b", k, done_a, (k == 17)); end
            n_checks++; if (busy_a !== (k <= 17)) begin n_fail++; $display("FAIL ramp_busy k=%0d: got %b expected %b", k, busy_a, (k <= 17)); end
        end
        $display("test_ramp done");
    endtask

    // All lines at MAX_T: a silent window with start and done 16 cycles apart.
    task automatic test_no_spike();
        valid_a = 1; times_a = 32'hFFFF_FFFF;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            valid_a = 0;
            #1;
            n_checks++; if (spikes_a !== 8'h00) begin n_fail++; $display("FAIL nospike_spikes k=%0d: got %h expected 00", k, spikes_a); end
            n_checks++; if (start_a !== (k == 1)) begin n_fail++; $display("FAIL nospike_start k=%0d: got %b expected %b", k, start_a, (k == 1)); end
            n_checks++; if (done_a !== (k == 17)) begin n_fail++; $display("FAIL nospike_done k=%0d: got %b expected %b", k, done_a, (k == 17)); end
        end
        $display("test_no_spike done");
    endtask

    // Valid held high with fresh data each cycle: accepts at cycles 0 and 18 only.
    task automatic test_back_to_back();
        logic [31:0] d0, d18;
        logic [7:0]  exp;
        d0  = b2b_data(0);
        d18 = b2b_data(18);
        for (int c = 0; c < 36; c++) begin
            if (c > 0) @(negedge clk);
            valid_a = 1; times_a = b2b_data(c);
            #1;
            exp = (c < 18) ? model_spikes(d0, c) : model_spikes(d18, c - 18);
            n_checks++; if (ready_a !== (c == 0 || c == 18)) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b expected %b", c, ready_a, (c == 0 || c == 18)); end
            n_checks++; if (spikes_a !== exp) begin n_fail++; $display("FAIL b2b_spikes c=%0d: got %h expected %h", c, spikes_a, exp); end
            n_checks++; if (start_a !== (c == 1 || c == 19)) begin n_fail++; $display("FAIL b2b_start c=%0d: got %b expected %b", c, start_a, (c == 1 || c == 19)); end
            n_checks++; if (done_a !== (c == 17 || c == 35)) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, done_a, (c == 17 || c == 35)); end
        end
        @(negedge clk);
        valid_a = 0;
        #1;
        n_checks++; if ({ready_a, busy_a} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle: got %b expected 10", {ready_a, busy_a}); end
        $display("test_back_to_back done");
    endtask

    // Abort at t=5 kills line 3 (time 9) and the done pulse; abort beats valid in IDLE.
    task automatic test_abort();
        logic [31:0] tv;
        logic [7:0]  exp;
        tv = 32'hFFFF_FFFF;
        tv[3:0]   = 4'd2;
        tv[15:12] = 4'd9;
        valid_a = 1; times_a = tv;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            valid_a = 0;
            abort_a = (k == 6) || (k == 21);
            if (k == 21) begin valid_a = 1; times_a = 32'h0000_0000; end
            #1;
            exp = (k <= 6) ? model_spikes(tv, k) : 8'h00;
            n_checks++; if (spikes_a !== exp) begin n_fail++; $display("FAIL abort_spikes k=%0d: got %h expected %h", k, spikes_a, exp); end
            n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL abort_done k=%0d: got %b expected 0", k, done_a); end
            if (k == 6 || k == 21) begin
                n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low k=%0d: got %b expected 0", k, ready_a); end
            end
            if (k == 7 || k == 22) begin
                n_checks++; if ({ready_a, busy_a} !== 2'b10) begin n_fail++; $display("FAIL abort_idle k=%0d: got %b expected 10", k, {ready_a, busy_a}); end
            end
        end
        abort_a = 0; valid_a = 0;
        $display("test_abort done");
    endtask

    // GAP_CYCLES=0, all times 0: all lines fire together, done in 15th RUN cycle, re-accept next.
    task automatic test_gap0();
        valid_b = 1; times_b = 32'h0000_0000;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            valid_b = (k == 16);
            times_b = 32'hFFFF_FFFF;
            #1;
            if (k <= 15) begin
                n_checks++; if (spikes_b !== ((k == 1) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL gap0_spikes k=%0d: got %h expected %h", k, spikes_b, (k == 1) ? 8'hFF : 8'h00); end
                n_checks++; if (done_b !== (k == 15)) begin n_fail++; $display("FAIL gap0_done k=%0d: got %b expected %b", k, done_b, (k == 15)); end
                n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL gap0_busy k=%0d: got %b expected 1", k, busy_b); end
            end
            if (k == 1 || k == 17) begin
                n_checks++; if (start_b !== 1'b1) begin n_fail++; $display("FAIL gap0_start k=%0d: got %b expected 1", k, start_b); end
            end
            if (k == 16 || k == 32) begin
                n_checks++; if ({ready_b, busy_b} !== 2'b10) begin n_fail++; $display("FAIL gap0_reaccept k=%0d: got %b expected 10", k, {ready_b, busy_b}); end
            end
            if (k > 16 && k < 32) begin
                n_checks++; if ({busy_b, spikes_b} !== 9'h100) begin n_fail++; $display("FAIL gap0_second k=%0d: got %h expected 100", k, {busy_b, spikes_b}); end
            end
        end
        valid_b = 0;
        $display("test_gap0 done");
    endtask

    // Reset dropped between edges at t=4 clears outputs at once; a new vector runs cleanly.
    task automatic test_async_reset();
        logic [31:0] tv;
        tv = 32'h7654_3210;
        valid_a = 1; times_a = tv;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            valid_a = 0;
        end
        #1;
        n_checks++; if (spikes_a !== 8'h10) begin n_fail++; $display("FAIL areset_before: got %h expected 10", spikes_a); end
        rst_l = 1'b0;
        #1;
        n_checks++; if ({spikes_a, busy_a, start_a, done_a} !== 11'h000) begin n_fail++; $display("FAIL areset_outputs: got %h expected 000", {spikes_a, busy_a, start_a, done_a}); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", ready_a); end
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++; if ({busy_a, spikes_a} !== 9'h000) begin n_fail++; $display("FAIL areset_no_resume k=%0d: got %h expected 000", k, {busy_a, spikes_a}); end
        end
        valid_a = 1; times_a = 32'h3333_3333;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            valid_a = 0;
            #1;
            n_checks++; if (spikes_a !== ((k == 4) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL areset_new_spikes k=%0d: got %h expected %h", k, spikes_a, (k == 4) ? 8'hFF : 8'h00); end
            n_checks++; if ({start_a, done_a} !== {(k == 1), (k == 17)}) begin n_fail++; $display("FAIL areset_new_pulses k=%0d: got %b expected %b", k, {start_a, done_a}, {(k == 1), (k == 17)}); end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ramp();
        test_no_spike();
        test_back_to_back();
        test_abort();
        test_gap0();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
